mux_scan_ctrl: RTL and testbench

Round-robin scan controller that sits directly upstream of the 8:1 four-bit channel multiplexer. It drives the mux select lines `s2`, `s1` and `s0`, and holds each selection for a programmable settle time. At the end of that time it captures the mux output `y` and presents it downstream as a tagged sample with a one-cycle valid strobe. Only channels whose request bit is high are scanned; the others are skipped.

---
 rtl/mux_scan_ctrl.sv | 107 ++++++++++
 tb/tb_mux_scan_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Round-robin scan controller for an 8:1 four-bit channel mux: selects each requesting
// channel in turn, waits DWELL cycles for the mux to settle, then emits a tagged sample.
module mux_scan_ctrl #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic [3:0] y_in,
    output logic       s2,
    output logic       s1,
    output logic       s0,
    output logic       busy,
    output logic [3:0] data_out,
    output logic [2:0] ch_out,
    output logic       valid
);

    typedef enum logic [0:0] {StIdle, StSettle} state_e;

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] sel_q, sel_d;
    logic [3:0] data_q, data_d;
    logic [2:0] ch_q, ch_d;
    logic       valid_q, valid_d;

    logic       grant_found;
    logic [2:0] grant_ch;

    // First set request bit at or above ptr, wrapping modulo 8; lowest offset wins.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = ptr_q;
        for (int i = 0; i < 8; i++) begin
            if (!grant_found && req[ptr_q + 3'(i)]) begin
                grant_found = 1'b1;
                grant_ch    = ptr_q + 3'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en && grant_found) begin
                    sel_d   = grant_ch;
                    cnt_d   = 8'(DWELL - 1);
                    state_d = StSettle;
                end
            end
            StSettle: begin
                // Abort beats capture when en drops on the final settle cycle.
                if (!en) begin
                    state_d = StIdle;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    data_d  = y_in;
                    ch_d    = sel_q;
                    valid_d = 1'b1;
                    ptr_d   = sel_q + 3'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= 3'd0;
            cnt_q   <= 8'd0;
            sel_q   <= 3'd0;
            data_q  <= 4'd0;
            ch_q    <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
        end
    end

    assign s2       = sel_q[2];
    assign s1       = sel_q[1];
    assign s0       = sel_q[0];
    assign busy     = (state_q == StSettle);
    assign data_out = data_q;
    assign ch_out   = ch_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: a transaction-level scan model predicts each capture,
// a negedge monitor checks select/busy every cycle and pops captures when valid strobes.
module tb_mux_scan_ctrl;

    localparam int unsigned DWELL = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [3:0] y_in;
    logic       s2, s1, s0, busy, valid;
    logic [3:0] data_out;
    logic [2:0] ch_out;

    logic [3:0] mux_in [8];

    mux_scan_ctrl #(.DWELL(DWELL)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .y_in(y_in),
        .s2(s2), .s1(s1), .s0(s0), .busy(busy),
        .data_out(data_out), .ch_out(ch_out), .valid(valid)
    );

    // The mux being scanned.
    assign y_in = mux_in[{s2, s1, s0}];

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] ch;
        logic [3:0] d;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit mon_on   = 1'b0;

    // Expected view of the current cycle, and the model of the scan.
    logic       exp_busy = 1'b0;
    logic [2:0] exp_sel  = 3'd0;
    logic [3:0] last_d   = 4'd0;
    logic [2:0] last_c   = 3'd0;
    bit         m_busy   = 1'b0;
    logic [2:0] m_sel    = 3'd0;
    logic [2:0] m_ptr    = 3'd0;
    int         m_start  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [2:0] first_from(input logic [2:0] p, input logic [7:0] r);
        for (int k = 0; k < 8; k++) begin
            if (r[(int'(p) + k) % 8]) return 3'((int'(p) + k) % 8);
        end
        return p;
    endfunction

    task automatic model_reset();
        sb.delete();
        m_busy = 1'b0; m_sel = 3'd0; m_ptr = 3'd0;
        exp_busy = 1'b0; exp_sel = 3'd0; last_d = 4'd0; last_c = 3'd0;
    endtask

    // One clock cycle: publish expectations, drive inputs, advance the model.
    task automatic step(input logic e, input logic [7:0] r, input bit rand_mux);
        @(posedge clk); #1;
        cyc++;
        exp_busy = m_busy;
        exp_sel  = m_sel;
        en  = e;
        req = r;
        if (rand_mux) for (int i = 0; i < 8; i++) mux_in[i] = 4'($urandom);
        if (!m_busy) begin
            if (e && r != 8'd0) begin
                m_sel   = first_from(m_ptr, r);
                m_busy  = 1'b1;
                m_start = cyc;
            end
        end else if (!e) begin
            m_busy = 1'b0;
        end else if (cyc == m_start + int'(DWELL)) begin
            sb.push_back('{cyc + 1, m_sel, mux_in[m_sel]});
            m_ptr  = m_sel + 3'd1;
            m_busy = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_on && !rst) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("sel", 32'({s2, s1, s0}), 32'(exp_sel));
            if (valid) begin
                if (sb.size() == 0) begin
                    chk("valid_unexpected", 32'(1), 32'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("valid_cycle", 32'(cyc), 32'(e.cyc));
                    last_d = e.d;
                    last_c = e.ch;
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                chk("valid_missing", 32'(0), 32'(1));
                void'(sb.pop_front());
            end
            chk("data_out", 32'(data_out), 32'(last_d));
            chk("ch_out", 32'(ch_out), 32'(last_c));
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; req = 8'd0;
        for (int i = 0; i < 8; i++) mux_in[i] = 4'd0;
        #2;
        chk("rst_outputs", 32'({s2, s1, s0, busy, valid, data_out, ch_out}), 32'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        mon_on = 1'b1;

        // Single channel, i3 = A.
        mux_in[3] = 4'hA;
        repeat (16) step(1'b1, 8'h08, 1'b0);

        // Round-robin with wrap between 0 and 7.
        mux_in[0] = 4'h1; mux_in[7] = 4'h7;
        repeat (22) step(1'b1, 8'h81, 1'b0);

        // Full scan, i_n = n.
        for (int i = 0; i < 8; i++) mux_in[i] = 4'(i);
        repeat (47) step(1'b1, 8'hFF, 1'b0);

        // Abort: park ptr at 5 via a capture on 4, abort channel 5, re-enable with all requests.
        repeat (2) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h10, 1'b0);
        repeat (DWELL + 1) step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h20, 1'b0);
        step(1'b1, 8'h20, 1'b0);
        step(1'b0, 8'h20, 1'b0);
        step(1'b0, 8'h20, 1'b0);
        repeat (8) step(1'b1, 8'hFF, 1'b0);

        // Late request drop: capture completes, then idle with sel held.
        repeat (2) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h04, 1'b0);
        repeat (10) step(1'b1, 8'h00, 1'b0);

        // Asynchronous reset in the middle of a settle.
        step(1'b1, 8'hC0, 1'b0);
        step(1'b1, 8'hC0, 1'b0);
        @(posedge clk); #3;
        mon_on = 1'b0;
        rst = 1'b1;
        en = 1'b0;
        #1;
        chk("rst_mid_settle", 32'({s2, s1, s0, busy, valid, data_out, ch_out}), 32'(0));
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        cyc++;
        mon_on = 1'b1;
        repeat (6) step(1'b0, 8'hFF, 1'b0);

        // Randomized scanning with a moving mux.
        repeat (800) begin
            logic [7:0] r;
            r = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
            step(($urandom_range(0, 19) != 0), r, 1'b1);
        end

        repeat (DWELL + 3) step(1'b0, 8'h00, 1'b0);
        chk("scoreboard_drained", 32'(sb.size()), 32'(0));
        mon_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
